// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - handshake bundle between byte sources, arbiter and UART transmitter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int DI_WIDTH = 8
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]          req_vld;
    logic [NUM_REQ*DI_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]          req_last;
    logic [NUM_REQ-1:0]          req_ack;
    logic [DI_WIDTH-1:0]         tx_din;
    logic                        tx_din_vld;
    logic                        tx_rfd;
    logic                        grant_vld;
    logic [IDW-1:0]              grant_id;

    modport master (output req_vld, req_data, req_last, tx_rfd,
                    input  req_ack, tx_din, tx_din_vld, grant_vld, grant_id);
    modport slave  (input  req_vld, req_data, req_last, tx_rfd,
                    output req_ack, tx_din, tx_din_vld, grant_vld, grant_id);
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin per-message arbiter sharing one UART transmitter
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DI_WIDTH     = 8,
    parameter int MAX_BURST    = 4,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam int TW  = $clog2(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t              state_q;
    logic [IDW-1:0]      ptr_q;
    logic [IDW-1:0]      grant_id_q;
    logic                grant_vld_q;
    logic                tx_din_vld_q;
    logic [DI_WIDTH-1:0] tx_din_q;
    logic [NUM_REQ-1:0]  req_ack_q;
    logic [BCW-1:0]      byte_cnt_q;
    logic [TW-1:0]       tmo_q;
    logic                last_flag_q;

    logic [IDW:0]        scan_sum;
    logic [IDW-1:0]      win_id_d;
    logic                win_vld_d;
    logic [IDW-1:0]      ptr_d;
    logic                cur_vld;
    logic                cur_last;
    logic [DI_WIDTH-1:0] cur_data;
    logic                burst_hit;

    // Scan downwards so the last hit written is the nearest index at or after ptr.
    always_comb begin
        win_vld_d = 1'b0;
        win_id_d  = '0;
        scan_sum  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (scan_sum >= (IDW+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (IDW+1)'(NUM_REQ);
            end
            if (bus.req_vld[scan_sum[IDW-1:0]]) begin
                win_vld_d = 1'b1;
                win_id_d  = scan_sum[IDW-1:0];
            end
        end
    end

    assign ptr_d     = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
    assign cur_vld   = bus.req_vld[grant_id_q];
    assign cur_last  = bus.req_last[grant_id_q];
    assign cur_data  = bus.req_data[grant_id_q*DI_WIDTH +: DI_WIDTH];
    assign burst_hit = (MAX_BURST != 0) && (byte_cnt_q == BCW'(MAX_BURST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            grant_id_q   <= '0;
            grant_vld_q  <= 1'b0;
            tx_din_vld_q <= 1'b0;
            tx_din_q     <= '0;
            req_ack_q    <= '0;
            byte_cnt_q   <= '0;
            tmo_q        <= '0;
            last_flag_q  <= 1'b0;
        end else begin
            tx_din_vld_q <= 1'b0;
            tx_din_q     <= '0;
            req_ack_q    <= '0;
            case (state_q)
                S_IDLE: begin
                    if (win_vld_d) begin
                        grant_vld_q <= 1'b1;
                        grant_id_q  <= win_id_d;
                        byte_cnt_q  <= '0;
                        tmo_q       <= '0;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cur_vld) begin
                        // A stalled transmitter is not the requester's fault, so the timeout holds.
                        if (bus.tx_rfd) begin
                            tx_din_vld_q <= 1'b1;
                            tx_din_q     <= cur_data;
                            req_ack_q    <= NUM_REQ'(1) << grant_id_q;
                            if (byte_cnt_q != {BCW{1'b1}}) begin
                                byte_cnt_q <= byte_cnt_q + 1'b1;
                            end
                            last_flag_q  <= cur_last;
                            tmo_q        <= '0;
                            state_q      <= S_WAIT_ACK;
                        end
                    end else if (tmo_q == TW'(IDLE_TIMEOUT - 1)) begin
                        grant_vld_q <= 1'b0;
                        ptr_q       <= ptr_d;
                        state_q     <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    state_q <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (bus.tx_rfd) begin
                        if (last_flag_q || burst_hit) begin
                            grant_vld_q <= 1'b0;
                            ptr_q       <= ptr_d;
                            state_q     <= S_IDLE;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.grant_vld  = grant_vld_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.tx_din_vld = tx_din_vld_q;
    assign bus.tx_din     = tx_din_q;
    assign bus.req_ack    = req_ack_q;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter among NUM_REQ byte sources.
- Grants the transmitter to one requester per message, ending at an end-of-message flag, a burst limit or an idle timeout.
- Feeds bytes one at a time through the transmitter's din/din_vld/rfd handshake.
- Sits between the protocol/console sources and the UART TX block.

Parameters:
- NUM_REQ, 4: number of requesters; 2..8.
- DI_WIDTH, 8: byte width; must match the transmitter.
- MAX_BURST, 4: maximum bytes per grant before a forced rotation; 0 means unlimited.
- IDLE_TIMEOUT, 16: cycles a granted requester may hold req_vld low mid-message before its grant is revoked; must be at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_vld  in  NUM_REQ  per-requester byte valid. Once high, it must stay high with stable data until acknowledged.
- req_data  in  NUM_REQ*DI_WIDTH  per-requester byte; requester i uses slice [i*DI_WIDTH +: DI_WIDTH].
- req_last  in  NUM_REQ  qualifies req_data as the final byte of a message.
- req_ack  out  NUM_REQ  one-cycle pulse: the offered byte was consumed.
- tx_din  out  DI_WIDTH  byte to the transmitter.
- tx_din_vld  out  1  one-cycle load strobe to the transmitter.
- tx_rfd  in  1  transmitter ready for data. It drops the cycle after a load and returns high when the frame completes.
- grant_vld  out  1  a requester currently owns the transmitter.
- grant_id  out  $clog2(NUM_REQ)  index of the owner; valid only while grant_vld is high.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer ptr=0, byte_cnt=0, timeout counter=0, last_flag=0.
- Reset mid-frame abandons the message. No ack is emitted.
- All outputs are registered.
- FSM states:
  - IDLE: if any req_vld is high, grant to the first asserted index scanning ptr, ptr+1, ... modulo NUM_REQ. Set grant_vld=1 and grant_id=winner, clear byte_cnt and the timeout counter, go to ISSUE.
  - ISSUE, when tx_rfd=1 and req_vld[g]=1: on the next cycle drive tx_din_vld=1, tx_din=req_data[g] and req_ack[g]=1, all for exactly one cycle. Increment byte_cnt, set last_flag=req_last[g], clear the timeout counter, go to WAIT_ACK.
  - ISSUE, when req_vld[g]=0: increment the timeout counter. On reaching IDLE_TIMEOUT-1, release and go to IDLE.
  - ISSUE, when tx_rfd=0 and req_vld[g]=1: wait. The timeout counter holds.
  - WAIT_ACK: the cycle in which tx_din_vld is high. Unconditionally go to WAIT_DONE.
  - WAIT_DONE: wait for tx_rfd=1. Then, if last_flag=1 or (MAX_BURST!=0 and byte_cnt==MAX_BURST), release and go to IDLE. Otherwise go to ISSUE.
- Release: grant_vld<=0 and ptr<=(g+1) modulo NUM_REQ, wrapping from NUM_REQ-1 to 0. grant_id keeps its last value.
- Requests from non-granted requesters are ignored. Their req_ack stays 0.
- Requests arriving in the same cycle as a release are arbitrated in the following IDLE cycle.
- Latency: request seen in IDLE at cycle t gives grant at t+1, ISSUE evaluates at t+1, and tx_din_vld is high at t+2 if tx_rfd=1.
- Between consecutive bytes of one message, IDLE is never re-entered, so no other requester can interleave.
- Widths:
  - byte_cnt is $clog2(MAX_BURST+1) bits (1 bit when MAX_BURST=0) and never wraps within a grant.
  - The timeout counter is $clog2(IDLE_TIMEOUT) bits and saturates at release.
- At most one bit of req_ack is high in any cycle, and req_ack is high only when tx_din_vld is high.
- tx_din_vld is never asserted while tx_rfd=0.

Test Plan:
1. Single byte, requester 2, data 0xA5, last=1, stub TX holding rfd low 40 cycles after load:
   - tx_din_vld is high exactly once, at t+2, with tx_din=0xA5 and req_ack=4'b0100.
   - grant_vld falls the cycle after rfd rises; ptr becomes 3.
2. Requesters 0 and 1 both send 1-byte messages continuously:
   - grants alternate 0, 1, 0, 1.
   - Requester 3 joining mid-run is granted after 1 (after 1 wraps to 0 via 3 only when 3 requests).
3. Requester 0 sends a 6-byte message, last on byte 6, while requester 1 is pending, MAX_BURST=4:
   - 0 sends bytes 1-4, then 1 is granted.
   - 0 resumes bytes 5-6 afterwards; no byte is lost or duplicated.
4. Requester 0 sends 1 byte with last=0, then drops req_vld:
   - grant_vld falls 16 cycles after ISSUE re-entry.
   - No extra tx_din_vld; ptr becomes 1.
5. rst asserted while in WAIT_DONE:
   - all outputs are 0 immediately (asynchronously).
   - After release, a requester-3-only request is granted to 3 (ptr=0 scan).
6. rfd held low by the stub while req_vld is stable:
   - no tx_din_vld and no timeout release.
   - Load occurs the cycle after rfd rises (observed one cycle later).
